// File: rtl/gam_winner_search_pkg.sv
// Shared constants, state encoding and default-width types for the GAM
// memory-layer winner search.
package gam_winner_search_pkg;

  localparam int DEF_NODE_COUNT  = 10;
  localparam int DEF_CLASS_COUNT = 4;
  localparam int DEF_VECTOR_LEN  = 16;
  localparam int DEF_PIXEL_W     = 8;
  localparam int DEF_LANES       = 4;
  localparam int DEF_DIST_W      = $clog2(DEF_VECTOR_LEN * (2 ** DEF_PIXEL_W - 1) + 1);
  localparam int DEF_NODE_W      = $clog2(DEF_NODE_COUNT + 1);
  localparam int DEF_CLASS_W     = $clog2(DEF_CLASS_COUNT + 1);
  localparam int DEF_VEC_W       = DEF_VECTOR_LEN * DEF_PIXEL_W;

  typedef logic [DEF_NODE_W-1:0] node_idx_T;
  typedef logic [DEF_DIST_W-1:0] dist_T;

  typedef enum logic [2:0] {
    WS_IDLE  = 3'd0,
    WS_FETCH = 3'd1,
    WS_WAIT  = 3'd2,
    WS_ACC   = 3'd3,
    WS_CMP   = 3'd4,
    WS_DONE  = 3'd5
  } ws_state_T;

endpackage

// File: rtl/gam_winner_search_if.sv
// Node-memory read bus: the searcher issues a one-cycle read strobe with
// class/node address; the memory returns W and Th on the following cycle.
interface gam_winner_search_if
  import gam_winner_search_pkg::*;
#(
  parameter int NODE_W  = DEF_NODE_W,
  parameter int CLASS_W = DEF_CLASS_W,
  parameter int VEC_W   = DEF_VEC_W,
  parameter int DIST_W  = DEF_DIST_W
) ();

  logic               rd_en;
  logic [CLASS_W-1:0] rd_class;
  logic [NODE_W-1:0]  rd_node;
  logic [VEC_W-1:0]   rd_w;
  logic [DIST_W-1:0]  rd_th;

  modport master (
    output rd_en, rd_class, rd_node,
    input  rd_w, rd_th
  );

  modport slave (
    input  rd_en, rd_class, rd_node,
    output rd_w, rd_th
  );

endinterface

// File: rtl/gam_winner_search_l1_lanes.sv
// Combinational partial L1 distance: sum of |x_i - w_i| over LANES pixels,
// zero-extended to the distance width. The caller registers the running sum.
module gam_l1_lanes #(
  parameter int PIXEL_W = 8,
  parameter int LANES   = 4,
  parameter int DIST_W  = 12
) (
  input  logic [LANES*PIXEL_W-1:0] i_x,
  input  logic [LANES*PIXEL_W-1:0] i_w,
  output logic [DIST_W-1:0]        o_sum
);

  function automatic logic [PIXEL_W-1:0] abs_diff(
    input logic [PIXEL_W-1:0] a,
    input logic [PIXEL_W-1:0] b
  );
    if (a > b) begin
      return a - b;
    end else begin
      return b - a;
    end
  endfunction

  logic [DIST_W-1:0] w_sum;

  // Adder tree over the lane absolute differences.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sum = w_sum + DIST_W'(abs_diff(i_x[i*PIXEL_W +: PIXEL_W], i_w[i*PIXEL_W +: PIXEL_W]));
    end
  end

  assign o_sum = w_sum;

endmodule

// File: rtl/gam_winner_search.sv
// GAM memory-layer winner search. Scans nodes 1..node_count of one class,
// accumulating L1 distance |X-W| LANES pixels per cycle, and tracks the two
// closest nodes. Flags new_node when no winner exists or the winner's
// distance exceeds its own threshold.
module gam_winner_search
  import gam_winner_search_pkg::*;
#(
  parameter int NODE_COUNT  = DEF_NODE_COUNT,
  parameter int CLASS_COUNT = DEF_CLASS_COUNT,
  parameter int VECTOR_LEN  = DEF_VECTOR_LEN,
  parameter int PIXEL_W     = DEF_PIXEL_W,
  parameter int LANES       = DEF_LANES,
  parameter int DIST_W      = $clog2(VECTOR_LEN * (2 ** PIXEL_W - 1) + 1),
  parameter int NODE_W      = $clog2(NODE_COUNT + 1),
  parameter int CLASS_W     = $clog2(CLASS_COUNT + 1),
  parameter int VEC_W       = VECTOR_LEN * PIXEL_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [CLASS_W-1:0]  i_class_sel,
  input  logic [NODE_W-1:0]   i_node_count,
  input  logic [VEC_W-1:0]    i_x_vec,
  gam_winner_search_if.master mem,
  output logic                o_busy,
  output logic                o_done,
  output logic [NODE_W-1:0]   o_win_idx,
  output logic [NODE_W-1:0]   o_sec_idx,
  output logic [DIST_W-1:0]   o_win_dist,
  output logic [DIST_W-1:0]   o_sec_dist,
  output logic                o_new_node
);

  localparam int ACC_CYCLES = VECTOR_LEN / LANES;
  localparam int LANE_W     = $clog2(ACC_CYCLES + 1);
  localparam int SLICE_W    = LANES * PIXEL_W;

  generate
    if (VECTOR_LEN % LANES != 0) begin : g_bad_lanes
      $error("gam_winner_search: VECTOR_LEN must be a multiple of LANES");
    end
  endgenerate

  ws_state_T            r_state;
  ws_state_T            w_state_nxt;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_rd_en;
  logic [CLASS_W-1:0]   r_class;
  logic [NODE_W-1:0]    r_cnt;
  logic [NODE_W-1:0]    r_node;
  logic [LANE_W-1:0]    r_lane;
  logic [VEC_W-1:0]     r_x;
  logic [VEC_W-1:0]     r_w;
  logic [DIST_W-1:0]    r_th;
  logic [DIST_W-1:0]    r_acc;
  logic [NODE_W-1:0]    r_win_idx;
  logic [DIST_W-1:0]    r_win_dist;
  logic [DIST_W-1:0]    r_win_th;
  logic [NODE_W-1:0]    r_sec_idx;
  logic [DIST_W-1:0]    r_sec_dist;
  logic                 r_new_node;

  logic [NODE_W-1:0]    w_cnt_in;
  logic [SLICE_W-1:0]   w_x_slice;
  logic [SLICE_W-1:0]   w_w_slice;
  logic [DIST_W-1:0]    w_lane_sum;
  logic                 w_last_lane;
  logic [NODE_W-1:0]    w_win_idx_nxt;
  logic [DIST_W-1:0]    w_win_dist_nxt;
  logic [DIST_W-1:0]    w_win_th_nxt;
  logic [NODE_W-1:0]    w_sec_idx_nxt;
  logic [DIST_W-1:0]    w_sec_dist_nxt;

  // Clamp the requested node count to the class capacity.
  always_comb begin
    if (i_node_count > NODE_W'(NODE_COUNT)) begin
      w_cnt_in = NODE_W'(NODE_COUNT);
    end else begin
      w_cnt_in = i_node_count;
    end
  end

  // Select the pixel group accumulated this cycle; r_lane stays in range.
  always_comb begin
    w_x_slice   = r_x[int'(r_lane)*SLICE_W +: SLICE_W];
    w_w_slice   = r_w[int'(r_lane)*SLICE_W +: SLICE_W];
    w_last_lane = (r_lane == LANE_W'(ACC_CYCLES - 1));
  end

  gam_l1_lanes #(
    .PIXEL_W (PIXEL_W),
    .LANES   (LANES),
    .DIST_W  (DIST_W)
  ) u_l1_lanes (
    .i_x   (w_x_slice),
    .i_w   (w_w_slice),
    .o_sum (w_lane_sum)
  );

  // Next-state logic. An empty class passes through CMP (with no node to
  // compare) so the done pulse still follows a fixed two-cycle path.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WS_IDLE: begin
        if (i_start) begin
          if (w_cnt_in == '0) begin
            w_state_nxt = WS_CMP;
          end else begin
            w_state_nxt = WS_FETCH;
          end
        end else begin
          w_state_nxt = WS_IDLE;
        end
      end
      WS_FETCH: w_state_nxt = WS_WAIT;
      WS_WAIT:  w_state_nxt = WS_ACC;
      WS_ACC: begin
        if (w_last_lane) begin
          w_state_nxt = WS_CMP;
        end else begin
          w_state_nxt = WS_ACC;
        end
      end
      WS_CMP: begin
        if (r_node < r_cnt) begin
          w_state_nxt = WS_FETCH;
        end else begin
          w_state_nxt = WS_DONE;
        end
      end
      WS_DONE:  w_state_nxt = WS_IDLE;
      default:  w_state_nxt = WS_IDLE;
    endcase
  end

  // Top-2 update: strict less-than so a tie keeps the earlier (lower) index.
  always_comb begin
    w_win_idx_nxt  = r_win_idx;
    w_win_dist_nxt = r_win_dist;
    w_win_th_nxt   = r_win_th;
    w_sec_idx_nxt  = r_sec_idx;
    w_sec_dist_nxt = r_sec_dist;
    if ((r_state == WS_CMP) && (r_node != '0)) begin
      if ((r_win_idx == '0) || (r_acc < r_win_dist)) begin
        w_sec_idx_nxt  = r_win_idx;
        w_sec_dist_nxt = r_win_dist;
        w_win_idx_nxt  = r_node;
        w_win_dist_nxt = r_acc;
        w_win_th_nxt   = r_th;
      end else if ((r_sec_idx == '0) || (r_acc < r_sec_dist)) begin
        w_sec_idx_nxt  = r_node;
        w_sec_dist_nxt = r_acc;
      end else begin
        w_sec_idx_nxt  = r_sec_idx;
        w_sec_dist_nxt = r_sec_dist;
      end
    end else begin
      w_win_idx_nxt = r_win_idx;
    end
  end

  // State register, status strobes, datapath and result tracker.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= WS_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_class    <= '0;
      r_cnt      <= '0;
      r_node     <= '0;
      r_lane     <= '0;
      r_x        <= '0;
      r_w        <= '0;
      r_th       <= '0;
      r_acc      <= '0;
      r_win_idx  <= '0;
      r_win_dist <= {DIST_W{1'b1}};
      r_win_th   <= '0;
      r_sec_idx  <= '0;
      r_sec_dist <= {DIST_W{1'b1}};
      r_new_node <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != WS_IDLE) && (w_state_nxt != WS_DONE);
      r_done  <= (w_state_nxt == WS_DONE);
      r_rd_en <= (w_state_nxt == WS_FETCH);
      case (r_state)
        WS_IDLE: begin
          if (i_start) begin
            r_class    <= i_class_sel;
            r_cnt      <= w_cnt_in;
            r_x        <= i_x_vec;
            r_node     <= (w_cnt_in == '0) ? NODE_W'(0) : NODE_W'(1);
            r_win_idx  <= '0;
            r_win_dist <= {DIST_W{1'b1}};
            r_win_th   <= '0;
            r_sec_idx  <= '0;
            r_sec_dist <= {DIST_W{1'b1}};
            r_new_node <= 1'b0;
          end
        end
        WS_WAIT: begin
          r_w    <= mem.rd_w;
          r_th   <= mem.rd_th;
          r_acc  <= '0;
          r_lane <= '0;
        end
        WS_ACC: begin
          r_acc  <= r_acc + w_lane_sum;
          r_lane <= w_last_lane ? LANE_W'(0) : r_lane + LANE_W'(1);
        end
        WS_CMP: begin
          r_win_idx  <= w_win_idx_nxt;
          r_win_dist <= w_win_dist_nxt;
          r_win_th   <= w_win_th_nxt;
          r_sec_idx  <= w_sec_idx_nxt;
          r_sec_dist <= w_sec_dist_nxt;
          if (r_node < r_cnt) begin
            r_node <= r_node + NODE_W'(1);
          end
          if (w_state_nxt == WS_DONE) begin
            r_new_node <= (w_win_idx_nxt == '0) || (w_win_dist_nxt > w_win_th_nxt);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem.rd_en    = r_rd_en;
  assign mem.rd_class = r_class;
  assign mem.rd_node  = r_node;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_win_idx    = r_win_idx;
  assign o_sec_idx    = r_sec_idx;
  assign o_win_dist   = r_win_dist;
  assign o_sec_dist   = r_sec_dist;
  assign o_new_node   = r_new_node;

endmodule
